// File: rtl/issue_pkg.sv
// Shared definitions for the issue scheduler: CDB source encodings and default unit latencies.
package issue_pkg;

  typedef logic [1:0] cdb_src_t;

  localparam cdb_src_t SRC_INT  = 2'd0;
  localparam cdb_src_t SRC_LDST = 2'd1;
  localparam cdb_src_t SRC_MULT = 2'd2;
  localparam cdb_src_t SRC_DIV  = 2'd3;

  localparam int MULT_LAT_DEF = 4;
  localparam int DIV_LAT_DEF  = 7;

  // Latency field wide enough to hold any latency up to max_lat+1.
  function automatic int lat_width(input int max_lat);
    return $clog2(max_lat + 2);
  endfunction

endpackage

// File: rtl/cdb_slot_ring.sv
// Reservation shift register for future CDB slots: slot j set means a result lands j cycles from now.
module cdb_slot_ring
  import issue_pkg::*;
#(
  parameter int DEPTH = DIV_LAT_DEF,
  parameter int LAT_W = lat_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             reserve,
  input  logic [LAT_W-1:0] latency,
  input  cdb_src_t         src,
  output logic [DEPTH:1]   free,
  output logic             head_valid,
  output cdb_src_t         head_src
);

  logic [DEPTH:1]      res_reg;
  logic [DEPTH:1]      res_next;
  logic [DEPTH:1][1:0] src_reg;
  logic [DEPTH:1][1:0] src_next;

  genvar gi;
  generate
    for (gi = 1; gi <= DEPTH; gi++) begin : g_slot
      logic hit;
      // A reservation with latency L lands in slot L-1 after this edge's shift.
      assign hit = reserve && (latency == LAT_W'(gi + 1));
      if (gi == DEPTH) begin : g_top
        assign res_next[gi] = hit;
        assign src_next[gi] = hit ? src : SRC_INT;
      end else begin : g_mid
        assign res_next[gi] = res_reg[gi+1] | hit;
        assign src_next[gi] = hit ? src : src_reg[gi+1];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_reg <= '0;
      src_reg <= '0;
    end else begin
      res_reg <= res_next;
      src_reg <= src_next;
    end
  end

  assign free       = ~res_reg;
  assign head_valid = res_reg[1];
  assign head_src   = src_reg[1];

endmodule

// File: rtl/issue_sched.sv
// Issue scheduler: grants one ready queue per cycle only when its CDB result slot is free.
module issue_sched
  import issue_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       issueint_ready,
  output logic       issueint_done,
  input  logic       issueldst_ready,
  output logic       issueldst_done,
  input  logic       issuemult_ready,
  output logic       issuemult_done,
  input  logic       issuediv_ready,
  output logic       issuediv_done,
  output logic [1:0] cdb_sel,
  output logic       cdb_sel_valid,
  output logic       div_busy
);

  localparam int LAT_W = lat_width(DIV_LAT);
  localparam int DCW   = $clog2(DIV_LAT + 1);

  logic [DIV_LAT:1] free;
  logic             head_valid;
  cdb_src_t         head_src;

  logic             rr_last_reg;
  logic [DCW-1:0]   div_cnt_reg;
  logic             cdb_valid_reg;
  cdb_src_t         cdb_sel_reg;

  logic int_elig, ldst_elig, mult_elig, div_elig;
  logic grant_int, grant_ldst, grant_mult, grant_div, grant_any;
  logic [LAT_W-1:0] grant_lat;
  cdb_src_t         grant_src;
  logic             cdb_valid_next;
  cdb_src_t         cdb_sel_next;
  logic             unused_free;

  assign int_elig  = issueint_ready  & free[1];
  assign ldst_elig = issueldst_ready & free[1];
  assign mult_elig = issuemult_ready & free[MULT_LAT];
  assign div_elig  = issuediv_ready  & free[DIV_LAT] & (div_cnt_reg == '0);

  // div > mult > round-robin pair; rr_last_reg=1 favours int on a tie.
  assign grant_div  = div_elig;
  assign grant_mult = mult_elig & ~div_elig;
  assign grant_int  = ~div_elig & ~mult_elig & int_elig  & (~ldst_elig | rr_last_reg);
  assign grant_ldst = ~div_elig & ~mult_elig & ldst_elig & (~int_elig  | ~rr_last_reg);
  assign grant_any  = grant_div | grant_mult | grant_int | grant_ldst;

  always_comb begin
    grant_lat = LAT_W'(1);
    grant_src = SRC_INT;
    if (grant_div) begin
      grant_lat = LAT_W'(DIV_LAT);
      grant_src = SRC_DIV;
    end else if (grant_mult) begin
      grant_lat = LAT_W'(MULT_LAT);
      grant_src = SRC_MULT;
    end else if (grant_ldst) begin
      grant_src = SRC_LDST;
    end
  end

  // Single-cycle ops match no ring stage; they go straight to the CDB register below.
  cdb_slot_ring #(
    .DEPTH (DIV_LAT),
    .LAT_W (LAT_W)
  ) u_ring (
    .clk        (clk),
    .reset_n    (reset_n),
    .reserve    (grant_any),
    .latency    (grant_lat),
    .src        (grant_src),
    .free       (free),
    .head_valid (head_valid),
    .head_src   (head_src)
  );

  always_comb begin
    cdb_valid_next = head_valid | grant_int | grant_ldst;
    cdb_sel_next   = SRC_INT;
    if (grant_ldst)
      cdb_sel_next = SRC_LDST;
    else if (!grant_int && head_valid)
      cdb_sel_next = head_src;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_last_reg   <= 1'b1;
      div_cnt_reg   <= '0;
      cdb_valid_reg <= 1'b0;
      cdb_sel_reg   <= SRC_INT;
    end else begin
      if (grant_int)
        rr_last_reg <= 1'b0;
      else if (grant_ldst)
        rr_last_reg <= 1'b1;
      if (grant_div)
        div_cnt_reg <= DCW'(DIV_LAT - 1);
      else if (div_cnt_reg != '0)
        div_cnt_reg <= div_cnt_reg - 1'b1;
      cdb_valid_reg <= cdb_valid_next;
      cdb_sel_reg   <= cdb_sel_next;
    end
  end

  // Grants are forced low while reset is held, independent of the ready inputs.
  assign issueint_done  = grant_int  & reset_n;
  assign issueldst_done = grant_ldst & reset_n;
  assign issuemult_done = grant_mult & reset_n;
  assign issuediv_done  = grant_div  & reset_n;

  assign cdb_sel_valid = cdb_valid_reg;
  assign cdb_sel       = cdb_sel_reg;
  assign div_busy      = (div_cnt_reg != '0);
  assign unused_free   = ^free;

endmodule

// File: tb/tb_issue_sched.sv
// Bench for issue_sched: directed scenarios plus random traffic against an absolute-time CDB calendar model.
module tb_issue_sched;

  localparam int MULT_LAT = 4;
  localparam int DIV_LAT  = 7;
  localparam int CAL_N    = 8192;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       issueint_ready, issueldst_ready, issuemult_ready, issuediv_ready;
  logic       issueint_done, issueldst_done, issuemult_done, issuediv_done;
  logic [1:0] cdb_sel;
  logic       cdb_sel_valid;
  logic       div_busy;

  issue_sched #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .issueint_ready  (issueint_ready),
    .issueint_done   (issueint_done),
    .issueldst_ready (issueldst_ready),
    .issueldst_done  (issueldst_done),
    .issuemult_ready (issuemult_ready),
    .issuemult_done  (issuemult_done),
    .issuediv_ready  (issuediv_ready),
    .issuediv_done   (issuediv_done),
    .cdb_sel         (cdb_sel),
    .cdb_sel_valid   (cdb_sel_valid),
    .div_busy        (div_busy)
  );

  always #5 clk = ~clk;

  // Calendar of CDB occupancy indexed by absolute cycle number.
  bit       cal_v [0:CAL_N-1];
  bit [1:0] cal_s [0:CAL_N-1];
  int       t;
  int       div_ok_at;
  bit       int_first;
  int       checks;
  int       errors;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, t, obs, exp_v);
    end
  endtask

  task automatic drive(input logic [3:0] rdy);
    {issuediv_ready, issuemult_ready, issueldst_ready, issueint_ready} = rdy;
  endtask

  task automatic reset_cycles(input int n, input logic [3:0] rdy);
    reset_n = 1'b0;
    drive(rdy);
    for (int i = 0; i < n; i++) begin
      for (int k = t; k < CAL_N; k++) begin
        cal_v[k] = 1'b0;
        cal_s[k] = 2'd0;
      end
      div_ok_at = 0;
      int_first = 1'b1;
      @(negedge clk);
      check("rst_done", {issuediv_done, issuemult_done, issueldst_done, issueint_done}, 4'b0000);
      check("rst_valid", cdb_sel_valid, 1'b0);
      check("rst_sel", cdb_sel, 2'd0);
      check("rst_busy", div_busy, 1'b0);
      @(posedge clk);
      #1;
      t++;
    end
    reset_n = 1'b1;
  endtask

  // rdy = {div, mult, ldst, int}
  task automatic do_cycle(input logic [3:0] rdy);
    logic [3:0] exp_done;
    int         lat;
    bit [1:0]   src;
    drive(rdy);
    @(negedge clk);
    exp_done = 4'b0000;
    lat = 0;
    src = 2'd0;
    if (rdy[3] && !cal_v[t+DIV_LAT] && t >= div_ok_at) begin
      exp_done = 4'b1000; lat = DIV_LAT; src = 2'd3;
    end else if (rdy[2] && !cal_v[t+MULT_LAT]) begin
      exp_done = 4'b0100; lat = MULT_LAT; src = 2'd2;
    end else if (rdy[0] && !cal_v[t+1] && (!rdy[1] || int_first)) begin
      exp_done = 4'b0001; lat = 1; src = 2'd0;
    end else if (rdy[1] && !cal_v[t+1]) begin
      exp_done = 4'b0010; lat = 1; src = 2'd1;
    end
    check("done", {issuediv_done, issuemult_done, issueldst_done, issueint_done}, exp_done);
    check("cdb_valid", cdb_sel_valid, cal_v[t]);
    if (cal_v[t])
      check("cdb_sel", cdb_sel, cal_s[t]);
    check("div_busy", div_busy, (t < div_ok_at));
    if (lat != 0) begin
      cal_v[t+lat] = 1'b1;
      cal_s[t+lat] = src;
      if (exp_done[3]) div_ok_at = t + DIV_LAT;
      if (exp_done[0]) int_first = 1'b0;
      if (exp_done[1]) int_first = 1'b1;
    end
    @(posedge clk);
    #1;
    t++;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    t = 0;
    div_ok_at = 0;
    int_first = 1'b1;
    reset_n = 1'b0;
    drive(4'b0000);

    // All ready during and after reset: div first, then mult.
    reset_cycles(3, 4'b1111);
    for (int i = 0; i < 20; i++) do_cycle(4'b1111);

    // int/ldst alternation.
    reset_cycles(1, 4'b0000);
    for (int i = 0; i < 10; i++) do_cycle(4'b0011);

    // Mult blocks int at the mult result slot.
    reset_cycles(1, 4'b0000);
    do_cycle(4'b0100);
    do_cycle(4'b0000);
    do_cycle(4'b0000);
    do_cycle(4'b0001);
    do_cycle(4'b0001);
    for (int i = 0; i < 3; i++) do_cycle(4'b0000);

    // Back-to-back divides.
    reset_cycles(1, 4'b0000);
    for (int i = 0; i < 16; i++) do_cycle(4'b1000);

    // Div slot blocks a mult.
    reset_cycles(1, 4'b0000);
    do_cycle(4'b1000);
    do_cycle(4'b0000);
    do_cycle(4'b0000);
    do_cycle(4'b0100);
    do_cycle(4'b0100);
    for (int i = 0; i < 6; i++) do_cycle(4'b0000);

    // Reset mid-divide drops its pending result.
    reset_cycles(1, 4'b0000);
    do_cycle(4'b1000);
    do_cycle(4'b0000);
    reset_cycles(2, 4'b0000);
    for (int i = 0; i < 8; i++) do_cycle(4'b0000);

    // Random traffic with occasional resets.
    for (int i = 0; i < 2500; i++) begin
      logic [3:0] rdy;
      rdy[0] = ($urandom_range(0, 9) < 6);
      rdy[1] = ($urandom_range(0, 9) < 6);
      rdy[2] = ($urandom_range(0, 9) < 3);
      rdy[3] = ($urandom_range(0, 9) < 2);
      if ($urandom_range(0, 199) == 0)
        reset_cycles(1 + int'($urandom_range(0, 2)), rdy);
      else
        do_cycle(rdy);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
